// File: rtl/csi_pckt_sequencer_if.sv
// csi_pckt_sequencer_if -- lane-merger input bundle and parsed packet output
// bundle for the CSI-2 packet sequencer. The sequencer uses the slave modport;
// whatever feeds it merged beats and consumes the parsed stream uses master.
interface csi_pckt_sequencer_if #(
   parameter int DATA_STREAM_WIDTH = 16,
   parameter int PH_STREAM_WIDTH   = 24
);
   // lane merger side
   logic                         sot;
   logic                         eot;
   logic                         lane_valid;
   logic [DATA_STREAM_WIDTH-1:0] lane_data;
   // parsed packet side
   logic [PH_STREAM_WIDTH-1:0]   ph_stream;
   logic [7:0]                   ph_ecc;
   logic                         ph_select;
   logic [DATA_STREAM_WIDTH-1:0] data_stream;
   logic [1:0]                   data_byte_en;
   logic                         valid_stream;
   logic                         pkt_active;
   logic                         seq_error;

   modport master (
      output sot, eot, lane_valid, lane_data,
      input  ph_stream, ph_ecc, ph_select, data_stream, data_byte_en,
             valid_stream, pkt_active, seq_error
   );

   modport slave (
      input  sot, eot, lane_valid, lane_data,
      output ph_stream, ph_ecc, ph_select, data_stream, data_byte_en,
             valid_stream, pkt_active, seq_error
   );
endinterface

// File: rtl/csi_pckt_sequencer.sv
// csi_pckt_sequencer -- splits a merged two-lane CSI-2 byte stream into the
// packet header {WC, DI} + ECC and the payload beats, dropping the CRC.
// Optional feature: define CSIRX_PKT_TIMEOUT_EN to abort a packet after
// TIMEOUT_CYCLES consecutive idle beats inside it.
module csi_pckt_sequencer #(
   parameter int DATA_STREAM_WIDTH = 16,
   parameter int PH_STREAM_WIDTH   = 24,
   parameter int TIMEOUT_CYCLES    = 255
) (
   input  logic                      rxbyteclkhs,
   input  logic                      reset_n,
   csi_pckt_sequencer_if.slave       lane
);

   typedef enum logic [2:0] {
      S_IDLE, S_PH0, S_PH1, S_PAYLOAD, S_CRC, S_WAIT_EOT
   } state_t;

   state_t                       r_state;
   state_t                       w_state_next;
   logic                         w_err;
   logic                         w_take;
   logic                         w_stall_state;
   logic                         w_tmo_hit;
   logic [15:0]                  w_wc;

   logic [7:0]                   r_di, w_di_next;
   logic [7:0]                   r_wc_lo, w_wc_lo_next;
   logic [15:0]                  r_byte_cnt, w_byte_cnt_next;
   logic [PH_STREAM_WIDTH-1:0]   r_ph_stream, w_ph_stream_next;
   logic [7:0]                   r_ph_ecc, w_ph_ecc_next;
   logic                         r_ph_select, w_ph_select_next;
   logic [DATA_STREAM_WIDTH-1:0] r_data_stream, w_data_stream_next;
   logic [1:0]                   r_byte_en, w_byte_en_next;
   logic                         r_valid, w_valid_next;

   logic                         r_pkt_active;
   logic                         r_seq_error;

   // States in which a beat is expected and a missing beat is a stall
   assign w_stall_state = (r_state == S_PH0) || (r_state == S_PH1) ||
                          (r_state == S_PAYLOAD) || (r_state == S_CRC);

   // A beat is consumed only when no sot/eot overrides it
   assign w_take = w_stall_state && lane.lane_valid && !lane.sot && !lane.eot;

   // Full word count as seen on the second header beat
   assign w_wc = {lane.lane_data[7:0], r_wc_lo};

`ifdef CSIRX_PKT_TIMEOUT_EN
   localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);
   logic [7:0] r_tmo_cnt, w_tmo_next;

   // Fires on the idle cycle that would bring the counter to TIMEOUT_CYCLES
   assign w_tmo_hit = w_stall_state && !lane.lane_valid && (r_tmo_cnt == TMO_LAST);

   // Count idle cycles; any beat or state change restarts the count
   always_comb begin
      w_tmo_next = r_tmo_cnt + 8'd1;
      if (lane.lane_valid || !w_stall_state || (w_state_next != r_state))
         w_tmo_next = 8'd0;
   end

   // Idle-cycle counter register
   always_ff @(posedge rxbyteclkhs or negedge reset_n) begin
      if (!reset_n) r_tmo_cnt <= 8'd0;
      else          r_tmo_cnt <= w_tmo_next;
   end
`else
   // Legal range is 1..255, so this folds to 0: stalls are unbounded
   assign w_tmo_hit = w_stall_state && !lane.lane_valid && (TIMEOUT_CYCLES == 0);
`endif

   // State register
   always_ff @(posedge rxbyteclkhs or negedge reset_n) begin
      if (!reset_n) r_state <= S_IDLE;
      else          r_state <= w_state_next;
   end

   // Next-state logic; sot beats eot beats timeout beats a data beat
   always_comb begin
      w_state_next = r_state;
      w_err        = 1'b0;
      if (r_state == S_IDLE) begin
         if (lane.sot) w_state_next = S_PH0;
      end else if (lane.sot) begin
         w_state_next = S_PH0;
         w_err        = 1'b1;
      end else if (lane.eot) begin
         w_state_next = S_IDLE;
         w_err        = (r_state != S_WAIT_EOT);
      end else if (w_tmo_hit) begin
         w_state_next = S_IDLE;
         w_err        = 1'b1;
      end else if (w_take) begin
         case (r_state)
            S_PH0:     w_state_next = S_PH1;
            S_PH1: begin
               if (r_di[5:0] < 6'h10) w_state_next = S_WAIT_EOT;
               else if (w_wc == 16'd0) w_state_next = S_CRC;
               else                    w_state_next = S_PAYLOAD;
            end
            // counter is never 0 here, so <= 2 means this beat empties it
            S_PAYLOAD: if (r_byte_cnt <= 16'd2) w_state_next = S_CRC;
            S_CRC:     w_state_next = S_WAIT_EOT;
            default:   w_state_next = r_state;
         endcase
      end
   end

   // Output/datapath next values; everything holds unless a beat is taken
   always_comb begin
      w_di_next          = r_di;
      w_wc_lo_next       = r_wc_lo;
      w_byte_cnt_next    = r_byte_cnt;
      w_ph_stream_next   = r_ph_stream;
      w_ph_ecc_next      = r_ph_ecc;
      w_ph_select_next   = 1'b0;
      w_data_stream_next = r_data_stream;
      w_byte_en_next     = r_byte_en;
      w_valid_next       = 1'b0;
      if (w_take) begin
         case (r_state)
            S_PH0: begin
               w_di_next    = lane.lane_data[7:0];
               w_wc_lo_next = lane.lane_data[15:8];
            end
            S_PH1: begin
               w_ph_stream_next = {w_wc, r_di};
               w_ph_ecc_next    = lane.lane_data[15:8];
               w_ph_select_next = 1'b1;
               w_valid_next     = 1'b1;
               w_byte_cnt_next  = w_wc;
            end
            S_PAYLOAD: begin
               w_data_stream_next = lane.lane_data;
               w_valid_next       = 1'b1;
               if (r_byte_cnt >= 16'd2) begin
                  w_byte_en_next  = 2'b11;
                  w_byte_cnt_next = r_byte_cnt - 16'd2;
               end else begin
                  // odd tail: upper byte is the CRC LSB and is masked off
                  w_byte_en_next  = 2'b01;
                  w_byte_cnt_next = r_byte_cnt - 16'd1;
               end
            end
            default: ;
         endcase
      end
   end

   // Output and datapath registers
   always_ff @(posedge rxbyteclkhs or negedge reset_n) begin
      if (!reset_n) begin
         r_di          <= '0;
         r_wc_lo       <= '0;
         r_byte_cnt    <= '0;
         r_ph_stream   <= '0;
         r_ph_ecc      <= '0;
         r_ph_select   <= 1'b0;
         r_data_stream <= '0;
         r_byte_en     <= '0;
         r_valid       <= 1'b0;
         r_pkt_active  <= 1'b0;
         r_seq_error   <= 1'b0;
      end else begin
         r_di          <= w_di_next;
         r_wc_lo       <= w_wc_lo_next;
         r_byte_cnt    <= w_byte_cnt_next;
         r_ph_stream   <= w_ph_stream_next;
         r_ph_ecc      <= w_ph_ecc_next;
         r_ph_select   <= w_ph_select_next;
         r_data_stream <= w_data_stream_next;
         r_byte_en     <= w_byte_en_next;
         r_valid       <= w_valid_next;
         r_pkt_active  <= (w_state_next != S_IDLE);
         r_seq_error   <= w_err;
      end
   end

   assign lane.ph_stream    = r_ph_stream;
   assign lane.ph_ecc       = r_ph_ecc;
   assign lane.ph_select    = r_ph_select;
   assign lane.data_stream  = r_data_stream;
   assign lane.data_byte_en = r_byte_en;
   assign lane.valid_stream = r_valid;
   assign lane.pkt_active   = r_pkt_active;
   assign lane.seq_error    = r_seq_error;

endmodule

// File: tb/tb_csi_pckt_sequencer.sv
// Directed testbench for csi_pckt_sequencer: one task per scenario, inline checks.
module tb_csi_pckt_sequencer;
`ifdef CSIRX_PKT_TIMEOUT_EN
   localparam int TB_TMO = 4;
`else
   localparam int TB_TMO = 255;
`endif

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   errors = 0;
   int   checks = 0;

   always #5 clk = ~clk;

   csi_pckt_sequencer_if bus ();

   csi_pckt_sequencer #(
      .DATA_STREAM_WIDTH(16),
      .PH_STREAM_WIDTH(24),
      .TIMEOUT_CYCLES(TB_TMO)
   ) dut (
      .rxbyteclkhs(clk),
      .reset_n(rst_n),
      .lane(bus)
   );

   // One clock cycle with the given inputs; returns 1 time unit after the edge
   task automatic cyc(input logic s, input logic e, input logic v, input logic [15:0] d);
      bus.sot = s; bus.eot = e; bus.lane_valid = v; bus.lane_data = d;
      @(posedge clk); #1;
      if (s | e | v)
         $display("beat sot=%0b eot=%0b vld=%0b data=%h -> vs=%0b phsel=%0b ph=%h ecc=%h ds=%h be=%b act=%0b err=%0b",
                  s, e, v, d, bus.valid_stream, bus.ph_select, bus.ph_stream, bus.ph_ecc,
                  bus.data_stream, bus.data_byte_en, bus.pkt_active, bus.seq_error);
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      bus.sot = 0; bus.eot = 0; bus.lane_valid = 0; bus.lane_data = 16'h0;
      repeat (2) @(posedge clk);
      #1;
      checks++; if (bus.ph_stream !== 24'h0) begin errors++; $display("FAIL reset_ph_stream got=%h exp=000000", bus.ph_stream); end
      checks++; if ({bus.valid_stream, bus.ph_select, bus.pkt_active, bus.seq_error} !== 4'b0) begin errors++; $display("FAIL reset_flags got=%b exp=0000", {bus.valid_stream, bus.ph_select, bus.pkt_active, bus.seq_error}); end
      checks++; if ({bus.data_stream, bus.data_byte_en, bus.ph_ecc} !== 26'h0) begin errors++; $display("FAIL reset_data got=%h exp=0", {bus.data_stream, bus.data_byte_en, bus.ph_ecc}); end
      rst_n = 1'b1;
      cyc(0, 0, 1, 16'h1234); // ignored in IDLE
      checks++; if (bus.pkt_active !== 1'b0 || bus.valid_stream !== 1'b0) begin errors++; $display("FAIL idle_ignore got=%b%b exp=00", bus.pkt_active, bus.valid_stream); end
   endtask

   task automatic test_short();
      cyc(1, 0, 0, 16'h0);
      checks++; if (bus.pkt_active !== 1'b1) begin errors++; $display("FAIL short_active got=%b exp=1", bus.pkt_active); end
      cyc(0, 0, 1, 16'h1000);
      checks++; if (bus.valid_stream !== 1'b0) begin errors++; $display("FAIL short_ph0_valid got=%b exp=0", bus.valid_stream); end
      cyc(0, 0, 1, 16'hAB00);
      checks++; if ({bus.ph_select, bus.valid_stream} !== 2'b11) begin errors++; $display("FAIL short_phsel got=%b exp=11", {bus.ph_select, bus.valid_stream}); end
      checks++; if (bus.ph_stream !== 24'h001000) begin errors++; $display("FAIL short_ph_stream got=%h exp=001000", bus.ph_stream); end
      checks++; if (bus.ph_ecc !== 8'hAB) begin errors++; $display("FAIL short_ecc got=%h exp=ab", bus.ph_ecc); end
      cyc(0, 0, 1, 16'h5555); // WAIT_EOT: no data forwarded
      checks++; if ({bus.ph_select, bus.valid_stream} !== 2'b00) begin errors++; $display("FAIL short_no_data got=%b exp=00", {bus.ph_select, bus.valid_stream}); end
      cyc(0, 1, 0, 16'h0);
      checks++; if ({bus.pkt_active, bus.seq_error} !== 2'b00) begin errors++; $display("FAIL short_eot got=%b exp=00", {bus.pkt_active, bus.seq_error}); end
   endtask

   task automatic test_long();
      cyc(1, 0, 0, 16'h0);
      cyc(0, 0, 1, 16'h042A);
      cyc(0, 0, 1, 16'h3F00);
      checks++; if (bus.ph_stream !== 24'h00042A || bus.ph_ecc !== 8'h3F) begin errors++; $display("FAIL long_header got=%h/%h exp=00042a/3f", bus.ph_stream, bus.ph_ecc); end
      cyc(0, 0, 1, 16'h2211);
      checks++; if ({bus.valid_stream, bus.ph_select, bus.data_byte_en, bus.data_stream} !== {1'b1, 1'b0, 2'b11, 16'h2211}) begin errors++; $display("FAIL long_beat0 got=%b%b %b %h exp=10 11 2211", bus.valid_stream, bus.ph_select, bus.data_byte_en, bus.data_stream); end
      cyc(0, 0, 1, 16'h4433);
      checks++; if ({bus.valid_stream, bus.data_byte_en, bus.data_stream} !== {1'b1, 2'b11, 16'h4433}) begin errors++; $display("FAIL long_beat1 got=%b %b %h exp=1 11 4433", bus.valid_stream, bus.data_byte_en, bus.data_stream); end
      cyc(0, 0, 1, 16'hBEEF); // CRC
      checks++; if ({bus.valid_stream, bus.pkt_active, bus.data_stream} !== {1'b0, 1'b1, 16'h4433}) begin errors++; $display("FAIL long_crc got=%b%b %h exp=01 4433", bus.valid_stream, bus.pkt_active, bus.data_stream); end
      cyc(0, 0, 1, 16'h9999); // WAIT_EOT
      checks++; if (bus.valid_stream !== 1'b0) begin errors++; $display("FAIL long_wait got=%b exp=0", bus.valid_stream); end
      cyc(0, 1, 0, 16'h0);
      checks++; if ({bus.pkt_active, bus.seq_error} !== 2'b00) begin errors++; $display("FAIL long_eot got=%b exp=00", {bus.pkt_active, bus.seq_error}); end
   endtask

   task automatic test_odd();
      cyc(1, 0, 0, 16'h0);
      cyc(0, 0, 1, 16'h032B);
      cyc(0, 0, 1, 16'h0000);
      cyc(0, 0, 1, 16'h2211);
      checks++; if ({bus.valid_stream, bus.data_byte_en} !== 3'b111) begin errors++; $display("FAIL odd_beat0 got=%b%b exp=111", bus.valid_stream, bus.data_byte_en); end
      cyc(0, 0, 1, 16'hCC33);
      checks++; if ({bus.valid_stream, bus.data_byte_en, bus.data_stream} !== {1'b1, 2'b01, 16'hCC33}) begin errors++; $display("FAIL odd_tail got=%b %b %h exp=1 01 cc33", bus.valid_stream, bus.data_byte_en, bus.data_stream); end
      cyc(0, 0, 1, 16'hDDDD); // CRC beat
      checks++; if (bus.valid_stream !== 1'b0) begin errors++; $display("FAIL odd_crc got=%b exp=0", bus.valid_stream); end
      cyc(0, 0, 1, 16'h7777); // WAIT_EOT
      checks++; if (bus.valid_stream !== 1'b0) begin errors++; $display("FAIL odd_wait got=%b exp=0", bus.valid_stream); end
      cyc(0, 1, 0, 16'h0);
      checks++; if (bus.seq_error !== 1'b0) begin errors++; $display("FAIL odd_eot_err got=%b exp=0", bus.seq_error); end
   endtask

   task automatic test_wc_zero();
      cyc(1, 0, 0, 16'h0);
      cyc(0, 0, 1, 16'h002A);
      cyc(0, 0, 1, 16'h0000);
      checks++; if (bus.ph_stream !== 24'h00002A || bus.ph_select !== 1'b1) begin errors++; $display("FAIL wc0_header got=%h %b exp=00002a 1", bus.ph_stream, bus.ph_select); end
      cyc(0, 1, 0, 16'h0); // still in CRC -> fault
      checks++; if ({bus.seq_error, bus.pkt_active} !== 2'b10) begin errors++; $display("FAIL wc0_crc_eot got=%b exp=10", {bus.seq_error, bus.pkt_active}); end
      cyc(1, 0, 0, 16'h0);
      cyc(0, 0, 1, 16'h002A);
      cyc(0, 0, 1, 16'h0000);
      cyc(0, 0, 1, 16'h9999); // CRC beat
      checks++; if (bus.valid_stream !== 1'b0) begin errors++; $display("FAIL wc0_crc_beat got=%b exp=0", bus.valid_stream); end
      cyc(0, 1, 0, 16'h0);
      checks++; if ({bus.seq_error, bus.pkt_active} !== 2'b00) begin errors++; $display("FAIL wc0_eot got=%b exp=00", {bus.seq_error, bus.pkt_active}); end
   endtask

   task automatic test_eot_abort();
      cyc(1, 0, 0, 16'h0);
      cyc(0, 0, 1, 16'h082A);
      cyc(0, 0, 1, 16'h0000);
      cyc(0, 0, 1, 16'h1111);
      cyc(0, 1, 0, 16'h0);
      checks++; if ({bus.seq_error, bus.pkt_active} !== 2'b10) begin errors++; $display("FAIL abort_eot got=%b exp=10", {bus.seq_error, bus.pkt_active}); end
      cyc(0, 0, 1, 16'h5678);
      checks++; if ({bus.seq_error, bus.valid_stream, bus.pkt_active} !== 3'b000) begin errors++; $display("FAIL abort_after got=%b exp=000", {bus.seq_error, bus.valid_stream, bus.pkt_active}); end
   endtask

   task automatic test_sot_restart();
      cyc(1, 0, 0, 16'h0);
      cyc(0, 0, 1, 16'h082A);
      cyc(0, 0, 1, 16'h0000);
      cyc(0, 0, 1, 16'h1111);
      cyc(1, 0, 1, 16'h2222);
      checks++; if ({bus.seq_error, bus.pkt_active, bus.valid_stream} !== 3'b110) begin errors++; $display("FAIL restart_sot got=%b exp=110", {bus.seq_error, bus.pkt_active, bus.valid_stream}); end
      cyc(0, 0, 1, 16'h3401);
      cyc(0, 0, 1, 16'h5600);
      checks++; if ({bus.ph_select, bus.ph_stream, bus.ph_ecc, bus.seq_error} !== {1'b1, 24'h003401, 8'h56, 1'b0}) begin errors++; $display("FAIL restart_header got=%b %h %h %b exp=1 003401 56 0", bus.ph_select, bus.ph_stream, bus.ph_ecc, bus.seq_error); end
      cyc(0, 1, 0, 16'h0);
      checks++; if ({bus.seq_error, bus.pkt_active} !== 2'b00) begin errors++; $display("FAIL restart_eot got=%b exp=00", {bus.seq_error, bus.pkt_active}); end
   endtask

   task automatic test_sot_eot_same();
      cyc(1, 0, 0, 16'h0);
      cyc(0, 0, 1, 16'h042A);
      cyc(1, 1, 0, 16'h0);
      checks++; if ({bus.seq_error, bus.pkt_active} !== 2'b11) begin errors++; $display("FAIL same_sot_eot got=%b exp=11", {bus.seq_error, bus.pkt_active}); end
      cyc(0, 0, 1, 16'h3401);
      cyc(0, 0, 1, 16'h5600);
      checks++; if (bus.ph_stream !== 24'h003401 || bus.ph_select !== 1'b1) begin errors++; $display("FAIL same_header got=%h %b exp=003401 1", bus.ph_stream, bus.ph_select); end
      cyc(0, 1, 0, 16'h0);
   endtask

   task automatic test_stall();
      int bad;
      bad = 0;
      cyc(1, 0, 0, 16'h0);
      cyc(0, 0, 1, 16'h042A);
      cyc(0, 0, 1, 16'h0000);
      cyc(0, 0, 1, 16'h2211);
`ifdef CSIRX_PKT_TIMEOUT_EN
      for (int i = 0; i < 3; i++) begin
         cyc(0, 0, 0, 16'h0);
         if (bus.seq_error !== 1'b0 || bus.valid_stream !== 1'b0) bad++;
      end
      checks++; if (bad != 0) begin errors++; $display("FAIL tmo_early got=%0d exp=0", bad); end
      cyc(0, 0, 0, 16'h0);
      checks++; if ({bus.seq_error, bus.pkt_active} !== 2'b10) begin errors++; $display("FAIL tmo_fire got=%b exp=10", {bus.seq_error, bus.pkt_active}); end
`else
      for (int i = 0; i < 300; i++) begin
         cyc(0, 0, 0, 16'h0);
         if (bus.seq_error !== 1'b0 || bus.valid_stream !== 1'b0 || bus.pkt_active !== 1'b1) bad++;
      end
      checks++; if (bad != 0) begin errors++; $display("FAIL stall_idle got=%0d exp=0", bad); end
      checks++; if (bus.data_stream !== 16'h2211) begin errors++; $display("FAIL stall_hold got=%h exp=2211", bus.data_stream); end
      cyc(0, 0, 1, 16'h4433);
      checks++; if ({bus.valid_stream, bus.data_byte_en, bus.data_stream} !== {1'b1, 2'b11, 16'h4433}) begin errors++; $display("FAIL stall_resume got=%b %b %h exp=1 11 4433", bus.valid_stream, bus.data_byte_en, bus.data_stream); end
      cyc(0, 0, 1, 16'hBEEF);
      cyc(0, 1, 0, 16'h0);
      checks++; if ({bus.seq_error, bus.pkt_active} !== 2'b00) begin errors++; $display("FAIL stall_eot got=%b exp=00", {bus.seq_error, bus.pkt_active}); end
`endif
   endtask

   task automatic test_mid_reset();
      cyc(1, 0, 0, 16'h0);
      cyc(0, 0, 1, 16'h082A);
      cyc(0, 0, 1, 16'h0000);
      cyc(0, 0, 1, 16'h1111);
      #2 rst_n = 1'b0;
      #1;
      checks++; if ({bus.pkt_active, bus.seq_error, bus.data_stream, bus.ph_stream} !== 42'h0) begin errors++; $display("FAIL async_reset got=%b%b %h %h exp=00 0000 000000", bus.pkt_active, bus.seq_error, bus.data_stream, bus.ph_stream); end
      @(posedge clk); #1;
      rst_n = 1'b1;
      cyc(0, 0, 0, 16'h0);
      checks++; if ({bus.seq_error, bus.pkt_active} !== 2'b00) begin errors++; $display("FAIL reset_no_err got=%b exp=00", {bus.seq_error, bus.pkt_active}); end
   endtask

   initial begin
      test_reset();
      test_short();
      test_long();
      test_odd();
      test_wc_zero();
      test_eot_abort();
      test_sot_restart();
      test_sot_eot_same();
      test_stall();
      test_mid_reset();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
